// File: rtl/keccak_padder_if.sv
// Word-source and block-sink signals of the Keccak input padder.
// The slave side is the padder itself; the master side is whoever feeds words and takes blocks.
interface keccak_padder_if #(
    parameter int WORD_W     = 64,
    parameter int RATE_WORDS = 9
);
    logic [WORD_W-1:0]            in;
    logic                         in_ready;
    logic                         is_last;
    logic [2:0]                   byte_num;
    logic                         buffer_full;
    logic [RATE_WORDS*WORD_W-1:0] out;
    logic                         out_ready;
    logic                         out_last;
    logic                         f_ack;

    modport master (
        output in, in_ready, is_last, byte_num, f_ack,
        input  buffer_full, out, out_ready, out_last
    );

    modport slave (
        input  in, in_ready, is_last, byte_num, f_ack,
        output buffer_full, out, out_ready, out_last
    );
endinterface

// File: rtl/keccak_padder.sv
// Packs 64-bit message words into rate blocks and applies Keccak pad10*1 to the final block.
// One message per reset: after the final block is acknowledged the padder parks in DONE.
module keccak_padder #(
    parameter int WORD_W     = 64,
    parameter int RATE_WORDS = 9
) (
    input  logic           clk,
    input  logic           reset,
    keccak_padder_if.slave bus
);
    localparam int BLOCK_W = RATE_WORDS * WORD_W;
    localparam int NBYTES  = WORD_W / 8;
    localparam int CNT_W   = $clog2(RATE_WORDS + 1);

    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(RATE_WORDS - 1);
    localparam logic [WORD_W-1:0] END_MARK  = WORD_W'(8'h80);

    typedef enum logic [1:0] {
        ABSORB,
        PAD,
        FULL,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BLOCK_W-1:0]   out_q, out_d;
    logic                 out_last_q, out_last_d;
    logic                 buffer_full_q, buffer_full_d;
    logic                 out_ready_q, out_ready_d;
    logic [WORD_W-1:0]    shift_word;
    logic                 final_slot;

    // Keep the k message bytes (MSB first), then 0x01, then zeros; the closing 0x80 lands in
    // the LSB byte only when this word fills the last slot of the block.
    function automatic logic [WORD_W-1:0] pad_word(
        input logic [WORD_W-1:0] w,
        input logic [2:0]        k,
        input logic              last_slot
    );
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i < int'(k)) r[WORD_W-1-8*i -: 8] = w[WORD_W-1-8*i -: 8];
            else if (i == int'(k)) r[WORD_W-1-8*i -: 8] = 8'h01;
        end
        if (last_slot) r = r | END_MARK;
        return r;
    endfunction

    assign final_slot = (count_q == LAST_SLOT);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        out_d      = out_q;
        out_last_d = out_last_q;
        shift_word = '0;

        unique case (state_q)
            ABSORB: begin
                if (bus.in_ready) begin
                    shift_word = bus.is_last ? pad_word(bus.in, bus.byte_num, final_slot) : bus.in;
                    out_d      = {out_q[BLOCK_W-WORD_W-1:0], shift_word};
                    count_d    = count_q + 1'b1;
                    if (final_slot) begin
                        state_d    = FULL;
                        out_last_d = bus.is_last;
                    end else if (bus.is_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                // Zero fill; the word that completes the block carries the trailing 1 bit.
                shift_word = final_slot ? END_MARK : '0;
                out_d      = {out_q[BLOCK_W-WORD_W-1:0], shift_word};
                count_d    = count_q + 1'b1;
                if (final_slot) begin
                    state_d    = FULL;
                    out_last_d = 1'b1;
                end
            end
            FULL: begin
                if (bus.f_ack) begin
                    count_d = '0;
                    state_d = out_last_q ? DONE : ABSORB;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = ABSORB;
            end
        endcase

        buffer_full_d = (state_d != ABSORB);
        out_ready_d   = (state_d == FULL);
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= ABSORB;
            count_q       <= '0;
            // NOTE: the block register is cleared because a zero block is visible after reset;
            // a buffer whose contents are never observed before being written would be left unreset.
            out_q         <= '0;
            out_last_q    <= 1'b0;
            buffer_full_q <= 1'b0;
            out_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            out_q         <= out_d;
            out_last_q    <= out_last_d;
            buffer_full_q <= buffer_full_d;
            out_ready_q   <= out_ready_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.out_ready   = out_ready_q;
    assign bus.out_last    = out_last_q;
    assign bus.buffer_full = buffer_full_q;
endmodule
